uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8N1 frames (start bit low, 8 data bits LSB-first, stop bit high, idle high) from a single asynchronous serial line. Oversamples at a fixed clocks-per-bit ratio and samples each bit at mid-bit. Presents each received byte with a one-cycle valid strobe. Sits at the line-side boundary opposite `uart_tx`, feeding byte-wide consumers in the `clk` domain.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit. Must be even and ≥ 4. `H = CLKS_PER_BIT/2`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data`  out  8  last good byte. Holds until the next good frame.
- `valid`  out  1  one-cycle pulse: `data` updated this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `busy`  out  1  high while a frame is in progress (START, DATA or STOP).

## Operation
- Input conditioning: `rx` passes through a 2-FF synchronizer, giving `rx_s`, which is `rx` delayed 2 cycles. `rx_q` is `rx_s` delayed 1 cycle, used for edge detect.
- FSM states: IDLE, START, DATA, STOP. One counter `cnt` with range 0..CLKS_PER_BIT-1, and a 3-bit bit index.
- IDLE:
  - A falling edge (`rx_q`=1, `rx_s`=0) moves to START with `cnt` cleared.
  - Low level without an edge is ignored. This covers a break or a stuck-low line after a framing error.
- START:
  - When `cnt`=H-1, sample `rx_s`.
  - Sample 0: go to DATA, clear `cnt` and the index.
  - Sample 1: glitch; return to IDLE with no output pulse.
- DATA:
  - When `cnt`=CLKS_PER_BIT-1, shift `rx_s` into the shift register at `index` (LSB first) and clear `cnt`.
  - After index 7 is sampled, go to STOP.
- STOP: when `cnt`=CLKS_PER_BIT-1, sample `rx_s`, then go to IDLE.
  - Sample 1: `data` is loaded from the shift register and `valid` pulses on the following cycle.
  - Sample 0: `frame_err` pulses on the following cycle and `data` is unchanged.
- `valid` and `frame_err` are registered, mutually exclusive, and never high for two consecutive cycles.
- No receive buffer. The consumer must take `data` before the next `valid`; an unread byte is silently overwritten.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, synchronizer and `rx_q` flops = 1 (idle line).
- Reset mid-frame: the partial frame is discarded, no pulse is issued, and reception restarts only on a new falling edge.

## Timing
- T0 is the first cycle with `rx_s`=0 after `rx_s`=1, i.e. 2 cycles after the raw `rx` falls.
- Start sample at T0+H.
- Data bit i sampled at T0+H+(i+1)·CLKS_PER_BIT, for i=0..7.
- Stop sample at T0+H+9·CLKS_PER_BIT.
- `valid`/`frame_err` high during cycle T0+H+9·CLKS_PER_BIT+1. `busy` falls in the same cycle.
- `busy` rises in cycle T0+1.
- The FSM is back in IDLE at the pulse cycle. A falling edge seen in that cycle or later starts a new frame, so back-to-back frames with a 1-bit stop are accepted.
- Tolerated baud mismatch: ±H/(10·CLKS_PER_BIT) cumulative. This is an informational limit and is not checked.

## Structure
- Shared package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP).
  - `UART_DATA_BITS`=8.
  - `UART_IDLE_LEVEL`=1'b1.
- The package is reused by `uart_tx`.
- One sub-module, `sync_2ff`: parameterised-width 2-flop synchronizer with a reset value parameter. Instantiated once for `rx`.
- The FSM, counter and shift register stay in `uart_rx`.

## Test plan
All scenarios use CLKS_PER_BIT=16 (H=8).
- Frame 0xA5, stop high → `valid` for exactly one cycle at T0+153 with `data`=0xA5. `frame_err` stays 0. `busy` is high from T0+1 to T0+152.
- `rx` low for 4 cycles, then high → no `valid` or `frame_err`. `busy` drops at T0+9. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit 0, line then held low for 40 cycles → `frame_err` pulse at T0+153 and `data` keeps its previous value. No new frame starts until `rx` goes high and falls again.
- Frames 0x00 then 0xFF back-to-back, each stop bit exactly 16 cycles → two `valid` pulses exactly 160 cycles apart, carrying `data` 0x00 then 0xFF.
- `rst` asserted for 1 cycle during data bit 4 → all outputs at reset values the next cycle and no pulse for that frame. A subsequent 0x5A frame gives `valid` with `data`=0x5A.
- Random bytes with ±2-cycle jitter on each bit edge, 500 frames → every byte matches the scoreboard and `frame_err` never asserts.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------
// uart_pkg : shared UART types and constants (used by rx and tx)
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------
// uart_rx_if : serial line plus byte-side outputs of the receiver
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      frame_err;
  logic                      busy;

  modport master (output rx, input data, valid, frame_err, busy);
  modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------
// sync_2ff : two-flop synchronizer with configurable reset value
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------
// uart_rx : 8N1 receiver, mid-bit sampling, one-cycle valid/error strobes
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_q;
  uart_state_t               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      rx_q    <= UART_IDLE_LEVEL;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_s;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge-triggered so a stuck-low line never restarts reception.
        if (rx_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------
// tb_uart_rx : directed + random self-checking bench for uart_rx
// ---------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;
  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int n_valid = 0, n_ferr = 0;
  int last_valid_cyc = -1, prev_valid_cyc = -1, last_ferr_cyc = -1;
  int busy_rise_cyc = -1, busy_fall_cyc = -1;
  logic busy_prev = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and busy edge tracker, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid || bus.frame_err) check("excl", 32'(bus.valid & bus.frame_err), 32'd0);
    if (bus.valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("valid_kind", 32'(e.err), 32'd0);
        check("valid_data", 32'(bus.data), 32'(e.data));
        last_good = e.data;
      end
    end else if (bus.frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
      if (sb.size() == 0) check("unexpected_ferr", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("ferr_kind", 32'(e.err), 32'd1);
        check("ferr_data_hold", 32'(bus.data), 32'(last_good));
      end
    end
    if (bus.busy && !busy_prev) busy_rise_cyc = cyc;
    if (!bus.busy && busy_prev) busy_fall_cyc = cyc;
    busy_prev = bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of a frame (start, 8 data, stop); entry at posedge+1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits, input bit jit);
    logic [9:0] bits;
    int j[11];
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 11; k++)
      j[k] = (jit && k > 0 && k < 10) ? int'($urandom_range(4, 0)) - 2 : 0;
    for (int k = 0; k < nbits; k++) begin
      bus.rx = bits[k];
      tick(16 + j[k+1] - j[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, nv, nf;
    logic [7:0] b;
    bus.rx = 1'b1;
    rst    = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    tick(20);

    // Good frame: pulse at raw-fall + 2 + 153
    sb.push_back('{1'b0, 8'hA5});
    e = cyc; nv = n_valid; nf = n_ferr;
    send_frame(8'hA5, 1'b1, 10, 1'b0);
    tick(5);
    check("a5_nvalid", 32'(n_valid - nv), 32'd1);
    check("a5_valid_cyc", 32'(last_valid_cyc), 32'(e + 155));
    check("a5_busy_rise", 32'(busy_rise_cyc), 32'(e + 3));
    check("a5_busy_fall", 32'(busy_fall_cyc), 32'(e + 155));
    check("a5_nferr", 32'(n_ferr - nf), 32'd0);

    // Short glitch: no pulse, busy drops at T0+9
    e = cyc; nv = n_valid; nf = n_ferr;
    bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    tick(30);
    check("glitch_nvalid", 32'(n_valid - nv), 32'd0);
    check("glitch_nferr", 32'(n_ferr - nf), 32'd0);
    check("glitch_busy_rise", 32'(busy_rise_cyc), 32'(e + 3));
    check("glitch_busy_fall", 32'(busy_fall_cyc), 32'(e + 11));
    sb.push_back('{1'b0, 8'h3C});
    nv = n_valid;
    send_frame(8'h3C, 1'b1, 10, 1'b0);
    tick(5);
    check("post_glitch_nvalid", 32'(n_valid - nv), 32'd1);
    check("post_glitch_data", 32'(bus.data), 32'h3C);

    // Framing error, then line stuck low
    sb.push_back('{1'b1, 8'h00});
    e = cyc; nv = n_valid; nf = n_ferr;
    send_frame(8'h3C, 1'b0, 10, 1'b0);
    tick(40);
    check("ferr_count", 32'(n_ferr - nf), 32'd1);
    check("ferr_cyc", 32'(last_ferr_cyc), 32'(e + 155));
    check("ferr_nvalid", 32'(n_valid - nv), 32'd0);
    check("ferr_data", 32'(bus.data), 32'h3C);
    check("ferr_low_busy", 32'(bus.busy), 32'd0);
    check("ferr_low_norestart", 32'(busy_rise_cyc), 32'(e + 3));
    bus.rx = 1'b1;
    tick(20);

    // Back-to-back frames with exactly one stop bit
    sb.push_back('{1'b0, 8'h00});
    sb.push_back('{1'b0, 8'hFF});
    e = cyc; nv = n_valid;
    send_frame(8'h00, 1'b1, 10, 1'b0);
    send_frame(8'hFF, 1'b1, 10, 1'b0);
    tick(5);
    check("b2b_nvalid", 32'(n_valid - nv), 32'd2);
    check("b2b_first_cyc", 32'(prev_valid_cyc), 32'(e + 155));
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd160);

    // Reset during data bit 4
    nv = n_valid; nf = n_ferr;
    send_frame(8'h10, 1'b1, 5, 1'b0);
    bus.rx = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check("mid_rst_data", 32'(bus.data), 32'h00);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    tick(200);
    check("mid_rst_nvalid", 32'(n_valid - nv), 32'd0);
    check("mid_rst_nferr", 32'(n_ferr - nf), 32'd0);
    sb.push_back('{1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 10, 1'b0);
    tick(5);
    check("post_rst_nvalid", 32'(n_valid - nv), 32'd1);
    check("post_rst_data", 32'(bus.data), 32'h5A);

    // Random bytes with edge jitter
    nv = n_valid; nf = n_ferr;
    for (int i = 0; i < 500; i++) begin
      b = 8'($urandom_range(255, 0));
      sb.push_back('{1'b0, b});
      send_frame(b, 1'b1, 10, 1'b1);
      if ($urandom_range(1, 0) == 1) tick(1);
    end
    tick(10);
    check("rand_nvalid", 32'(n_valid - nv), 32'd500);
    check("rand_nferr", 32'(n_ferr - nf), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
